seq_detector: RTL and testbench

//  Overlapping serial bit-pattern detector, Moore style. Samples one bit of x per clk

---
 rtl/seq_det_pkg.sv | 12 +
 rtl/seq_det_next.sv | 54 +++++
 rtl/seq_detector.sv | 45 ++++
 tb/tb_seq_detector.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the overlapping serial pattern detector.
package seq_det_pkg;

    localparam int DEF_PAT_LEN = 4;
    localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 4'b1101;

    // Enough bits to encode states 0..pat_len.
    function automatic int state_w(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

endpackage

// File: rtl/seq_det_next.sv
// Combinational next-state lookup for the pattern detector; zero latency.
// The table is computed at elaboration from PATTERN, so synthesis sees only a constant ROM.
module seq_det_next
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter int                 SW      = state_w(PAT_LEN)
) (
    input  logic [SW-1:0] state,
    input  logic          x,
    output logic [SW-1:0] next_state
);

    localparam int NS = 2 ** SW;

    // Entry (k, b): longest pattern prefix that is a suffix of (first k pattern bits, b).
    // Encodings above PAT_LEN stay zero so stray states fall back to S0.
    function automatic logic [NS*2*SW-1:0] build_table();
        logic [NS*2*SW-1:0] t;
        int                 best;
        int                 j;
        bit                 ok;
        logic               s_bit;
        t = '0;
        for (int k = 0; k <= PAT_LEN; k++) begin
            for (int b = 0; b < 2; b++) begin
                best = 0;
                for (int l = 1; l <= PAT_LEN && l <= k + 1; l++) begin
                    ok = 1'b1;
                    for (int i = 0; i < l; i++) begin
                        j = k + 1 - l + i;
                        if (j == k) s_bit = b[0];
                        else        s_bit = PATTERN[PAT_LEN-1-j];
                        if (PATTERN[PAT_LEN-1-i] != s_bit) ok = 1'b0;
                    end
                    if (ok) best = l;
                end
                t[(k*2+b)*SW +: SW] = SW'(best);
            end
        end
        return t;
    endfunction

    localparam logic [NS*2*SW-1:0] NEXT_TBL = build_table();

    logic [SW:0] idx;

    always_comb begin
        idx        = {state, x};
        next_state = NEXT_TBL[int'(idx)*SW +: SW];
    end

endmodule

// File: rtl/seq_detector.sv
// Overlapping Moore pattern detector: z pulses one cycle after the edge sampling the last bit.
// State and z are both flops; there is no combinational path from x to z.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
    input  logic x,
    input  logic clk,
    input  logic reset,
    output logic z
);

    localparam int SW = state_w(PAT_LEN);

    if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
        $error("seq_detector: PAT_LEN must be within 2..16");
    end

    logic [SW-1:0] state;
    logic [SW-1:0] next_state;

    seq_det_next #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN),
        .SW      (SW)
    ) u_next (
        .state      (state),
        .x          (x),
        .next_state (next_state)
    );

    // z is registered from the same next-state value, so it always equals (state == PAT_LEN).
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= '0;
            z     <= 1'b0;
        end else begin
            state <= next_state;
            z     <= (next_state == SW'(PAT_LEN));
        end
    end

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench for seq_detector: a shift-register reference model predicts z for three configurations.
module tb_seq_detector;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic x0 = 1'b0, x2 = 1'b0, x5 = 1'b0;
    logic z0, z2, z5;

    int vectors = 0;
    int miscompares = 0;

    bit q0[$];
    bit q2[$];
    bit q5[$];

    logic [3:0] h0 = '0;
    logic [1:0] h2 = '0;
    logic [4:0] h5 = '0;
    int c0 = 0, c2 = 0, c5 = 0;

    always #5 clk = ~clk;

    seq_detector dut0 (.x(x0), .clk(clk), .reset(reset), .z(z0));
    seq_detector #(.PAT_LEN(2), .PATTERN(2'b11))    dut2 (.x(x2), .clk(clk), .reset(reset), .z(z2));
    seq_detector #(.PAT_LEN(5), .PATTERN(5'b10101)) dut5 (.x(x5), .clk(clk), .reset(reset), .z(z5));

    // Drive one sample, advance the reference model, push predictions, then wait past the edge.
    task automatic step(input logic r, input logic b0, input logic b2, input logic b5);
        @(negedge clk);
        reset = r;
        x0 = b0;
        x2 = b2;
        x5 = b5;
        if (!r) begin
            h0 = '0; h2 = '0; h5 = '0;
            c0 = 0;  c2 = 0;  c5 = 0;
        end else begin
            h0 = {h0[2:0], b0}; if (c0 < 4) c0++;
            h2 = {h2[0], b2};   if (c2 < 2) c2++;
            h5 = {h5[3:0], b5}; if (c5 < 5) c5++;
        end
        q0.push_back(r && c0 >= 4 && h0 == 4'b1101);
        q2.push_back(r && c2 >= 2 && h2 == 2'b11);
        q5.push_back(r && c5 >= 5 && h5 == 5'b10101);
        @(posedge clk);
        #1;
    endtask

    task automatic flush_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        void'(q0.pop_front()); void'(q2.pop_front()); void'(q5.pop_front());
    endtask

    task automatic test_reset();
        bit e;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'bx, 1'bx, 1'bx);
            e = q0.pop_front(); void'(q2.pop_front()); void'(q5.pop_front());
            vectors++;
            if (z0 !== e) begin
                miscompares++;
                $display("FAIL reset_z[%0d] got %b want %b", i, z0, e);
            end
            vectors++;
            if (dut0.state !== 3'd0) begin
                miscompares++;
                $display("FAIL reset_state[%0d] got %0d want 0", i, dut0.state);
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        e = q0.pop_front(); void'(q2.pop_front()); void'(q5.pop_front());
        vectors++;
        if (z0 !== e) begin
            miscompares++;
            $display("FAIL release_z got %b want %b", z0, e);
        end
    endtask

    task automatic run_stream0(input string name, input bit s[], input bit rst_mask[], input int want_pulses);
        bit e;
        int pulses = 0;
        for (int i = 0; i < s.size(); i++) begin
            step(rst_mask[i], s[i], s[i], s[i]);
            e = q0.pop_front(); void'(q2.pop_front()); void'(q5.pop_front());
            vectors++;
            if (z0 !== e) begin
                miscompares++;
                $display("FAIL %s[%0d] z got %b want %b", name, i, z0, e);
            end
            if (z0 === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != want_pulses) begin
            miscompares++;
            $display("FAIL %s_pulses got %0d want %0d", name, pulses, want_pulses);
        end
    endtask

    task automatic test_overlap();
        flush_reset();
        run_stream0("overlap", '{0,1,1,0,1,1,0,1}, '{1,1,1,1,1,1,1,1}, 2);
    endtask

    task automatic test_no_false_hit();
        flush_reset();
        run_stream0("no_false", '{1,1,1,0,0,1,0,1,0,0,0,0}, '{1,1,1,1,1,1,1,1,1,1,1,1}, 0);
    endtask

    task automatic test_transitions();
        int  want_nx [5][2] = '{'{0,1}, '{0,2}, '{3,2}, '{0,4}, '{0,2}};
        bit  pat [4] = '{1,1,0,1};
        for (int k = 0; k <= 4; k++) begin
            for (int b = 0; b < 2; b++) begin
                flush_reset();
                for (int i = 0; i < k; i++) begin
                    step(1'b1, pat[i], 1'b0, 1'b0);
                    void'(q0.pop_front()); void'(q2.pop_front()); void'(q5.pop_front());
                end
                step(1'b1, b[0], 1'b0, 1'b0);
                void'(q0.pop_front()); void'(q2.pop_front()); void'(q5.pop_front());
                vectors++;
                if (int'(dut0.state) != want_nx[k][b]) begin
                    miscompares++;
                    $display("FAIL trans_S%0d_x%0d got S%0d want S%0d", k, b, dut0.state, want_nx[k][b]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        flush_reset();
        run_stream0("mid_reset_a", '{1,1,0,1,1}, '{1,1,1,0,1}, 0);
        run_stream0("mid_reset_b", '{1,1,0,1}, '{1,1,1,1}, 1);
    endtask

    task automatic test_param_sweep();
        bit s2 [4] = '{1,1,1,1};
        bit s5 [7] = '{1,0,1,0,1,0,1};
        bit e;
        int pulses;
        flush_reset();
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, s2[i], 1'b0);
            void'(q0.pop_front()); e = q2.pop_front(); void'(q5.pop_front());
            vectors++;
            if (z2 !== e) begin
                miscompares++;
                $display("FAIL len2[%0d] z got %b want %b", i, z2, e);
            end
            if (z2 === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 3) begin
            miscompares++;
            $display("FAIL len2_pulses got %0d want 3", pulses);
        end
        flush_reset();
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, 1'b0, s5[i]);
            void'(q0.pop_front()); void'(q2.pop_front()); e = q5.pop_front();
            vectors++;
            if (z5 !== e) begin
                miscompares++;
                $display("FAIL len5[%0d] z got %b want %b", i, z5, e);
            end
            if (z5 === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 2) begin
            miscompares++;
            $display("FAIL len5_pulses got %0d want 2", pulses);
        end
    endtask

    task automatic test_long_idle();
        bit s [204];
        bit r [204];
        bit tail [4] = '{1,1,0,1};
        for (int i = 0; i < 204; i++) begin
            s[i] = (i < 200) ? 1'b0 : tail[i-200];
            r[i] = 1'b1;
        end
        flush_reset();
        run_stream0("long_idle", s, r, 1);
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_no_false_hit();
        test_transitions();
        test_mid_reset();
        test_param_sweep();
        test_long_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
